// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential shift-add multiplier, unsigned or two's-complement, GO/BUSY/DONE handshake
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 SYS_CLOCK,
    input  logic                 FSM_ARESET_N,
    input  logic                 GO,
    input  logic                 SIGNED_MODE,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   F_REG,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;
    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_mag_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               w_accept;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_sum;
    // magnitudes fit WIDTH bits even for the most-negative operand; carry lands in w_sum[WIDTH]
    assign w_mag_a  = (SIGNED_MODE && A[WIDTH-1]) ? -A : A;
    assign w_mag_b  = (SIGNED_MODE && B[WIDTH-1]) ? -B : B;
    assign w_accept = GO && (r_state == S_IDLE || r_state == S_DONE);
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    // state register
    always_ff @(posedge SYS_CLOCK or negedge FSM_ARESET_N) begin
        if (!FSM_ARESET_N) r_state <= S_IDLE;
        else               r_state <= w_next;
    end
    // next state and handshake outputs
    always_comb begin
        w_next = w_accept ? S_CALC :
                 (r_state == S_CALC && r_cnt == CW'(WIDTH-1)) ? S_SIGN :
                 (r_state == S_SIGN) ? S_DONE :
                 (r_state == S_DONE) ? S_IDLE : r_state;
        BUSY   = (r_state == S_CALC) || (r_state == S_SIGN);
        DONE   = (r_state == S_DONE);
    end
    // datapath: low half of acc starts as |B| and shifts out one multiplier bit per CALC cycle
    always_ff @(posedge SYS_CLOCK or negedge FSM_ARESET_N) begin
        if (!FSM_ARESET_N) begin
            r_mag_a <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            F_REG   <= '0;
        end else begin
            if (w_accept) begin
                r_mag_a <= w_mag_a;
                r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                r_neg   <= SIGNED_MODE & (A[WIDTH-1] ^ B[WIDTH-1]);
                r_cnt   <= '0;
            end else if (r_state == S_CALC) begin
                r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
                r_cnt   <= r_cnt + CW'(1);
            end
            if (r_state == S_SIGN) F_REG <= r_neg ? -r_acc : r_acc;
        end
    end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: randomized self-checking bench against an arithmetic reference model
module tb_seq_shift_add_mult;
    logic clk = 1'b0, rst_n = 1'b0;
    logic go8 = 0, sm8 = 0, go5 = 0, sm5 = 0, go3 = 0, sm3 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic [4:0] a5 = 0, b5 = 0;
    logic [2:0] a3 = 0, b3 = 0;
    logic [15:0] f8;
    logic [9:0] f5;
    logic [5:0] f3;
    logic busy8, done8, busy5, done5, busy3, done3;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    seq_shift_add_mult #(.WIDTH(8)) d8 (.SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go8), .SIGNED_MODE(sm8),
        .A(a8), .B(b8), .F_REG(f8), .BUSY(busy8), .DONE(done8));
    seq_shift_add_mult #(.WIDTH(5)) d5 (.SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go5), .SIGNED_MODE(sm5),
        .A(a5), .B(b5), .F_REG(f5), .BUSY(busy5), .DONE(done5));
    seq_shift_add_mult #(.WIDTH(3)) d3 (.SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go3), .SIGNED_MODE(sm3),
        .A(a3), .B(b3), .F_REG(f3), .BUSY(busy3), .DONE(done3));

    // product of the interpreted operand values, truncated to 2*w bits
    function automatic logic [15:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b, input logic sm);
        longint sa = longint'(a), sb = longint'(b), p, m;
        if (sm && a[w-1]) sa -= (longint'(1) << w);
        if (sm && b[w-1]) sb -= (longint'(1) << w);
        m = (longint'(1) << (2*w)) - 1;
        p = (sa * sb) & m;
        return p[15:0];
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : (w == 5) ? done5 : done3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    // one complete operation on the chosen instance; lat = edges from accept to DONE (0 = timeout)
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sm,
                         output logic [15:0] res, output int lat);
        @(negedge clk);
        if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; go8 = 1; end
        else if (w == 5) begin a5 = a[4:0]; b5 = b[4:0]; sm5 = sm; go5 = 1; end
        else begin a3 = a[2:0]; b3 = b[2:0]; sm3 = sm; go3 = 1; end
        @(posedge clk); #1;
        go8 = 0; go5 = 0; go3 = 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_of(w)) begin lat = i; break; end
        end
        res = (w == 8) ? f8 : (w == 5) ? {6'b0, f5} : {10'b0, f3};
    endtask

    task automatic test_reset();
        #2;
        check("reset_f8", 32'(f8), 0);
        check("reset_busy8", 32'(busy8), 0);
        check("reset_done8", 32'(done8), 0);
        check("reset_f5", 32'(f5), 0);
        check("reset_f3", 32'(f3), 0);
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_width3();
        logic [15:0] r; int lat;
        do_op(3, 16'd7, 16'd3, 1'b0, r, lat);
        check("w3_latency", 32'(lat), 4);
        check("w3_7x3", 32'(r), 21);
    endtask

    task automatic test_corners();
        logic [15:0] r; int lat;
        logic [15:0] va [4] = '{16'hFF, 16'h80, 16'hFF, 16'h00};
        logic [15:0] vb [4] = '{16'hFF, 16'h80, 16'h7F, 16'hFB};
        logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] ve [4] = '{16'hFE01, 16'h4000, 16'hFF81, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            do_op(8, va[i], vb[i], vs[i], r, lat);
            check($sformatf("corner%0d", i), 32'(r), 32'(ve[i]));
        end
    endtask

    task automatic test_latency();
        logic [15:0] a, b, prev; logic sm;
        for (int n = 0; n < 2; n++) begin
            a = 16'($urandom_range(1, 255)); b = 16'($urandom_range(1, 255)); sm = n[0];
            @(negedge clk); a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; go8 = 1;
            @(posedge clk); #1; go8 = 0; prev = f8;
            for (int k = 1; k <= 9; k++) begin
                @(posedge clk); #1;
                check($sformatf("lat_busy_k%0d", k), 32'(busy8), 32'(k <= 8));
                check($sformatf("lat_done_k%0d", k), 32'(done8), 32'(k == 9));
                if (k <= 8) check($sformatf("lat_hold_k%0d", k), 32'(f8), 32'(prev));
            end
            check("lat_result", 32'(f8), 32'(ref_mul(8, a, b, sm)));
            @(posedge clk); #1;
            check("lat_done_drop", 32'(done8), 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b; logic sm; int gap;
        a = 16'($urandom & 8'hFF); b = 16'($urandom & 8'hFF); sm = 1'b1;
        @(negedge clk); a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; go8 = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            for (int i = 1; i <= 30; i++) begin
                @(posedge clk); #1;
                if (done8) begin gap = i; break; end
            end
            if (k == 2) go8 = 0;
            check($sformatf("b2b_gap%0d", k), 32'(gap), (k == 0) ? 9 : 10);
            check($sformatf("b2b_val%0d", k), 32'(f8), 32'(ref_mul(8, a, b, sm)));
        end
        @(posedge clk); #1;
        check("b2b_idle_busy", 32'(busy8), 0);
    endtask

    task automatic test_busy_ignore();
        logic [15:0] a, b, exp; logic sm; int lat, extra;
        a = 16'($urandom_range(1, 255)); b = 16'($urandom_range(1, 255)); sm = 1'b0;
        exp = ref_mul(8, a, b, sm);
        @(negedge clk); a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; go8 = 1;
        @(posedge clk); #1; go8 = 0;
        @(negedge clk); a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'b1; go8 = 1;
        @(negedge clk); go8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        for (int i = 2; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done8) begin lat = i; break; end
        end
        check("ign_latency", 32'(lat), 9);
        check("ign_result", 32'(f8), 32'(exp));
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) extra++;
        end
        check("ign_not_queued", 32'(extra), 0);
    endtask

    task automatic test_async_reset();
        logic [15:0] r; int lat, dn;
        @(negedge clk); a8 = 8'd200; b8 = 8'd3; sm8 = 0; go8 = 1;
        @(posedge clk); #1; go8 = 0;
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("arst_f", 32'(f8), 0);
        check("arst_busy", 32'(busy8), 0);
        check("arst_done", 32'(done8), 0);
        @(negedge clk); rst_n = 1;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done8) dn++;
        end
        check("arst_no_done", 32'(dn), 0);
        do_op(8, 16'h85, 16'h13, 1'b1, r, lat);
        check("arst_after", 32'(r), 32'(ref_mul(8, 16'h85, 16'h13, 1'b1)));
    endtask

    task automatic test_random();
        logic [15:0] a, b, r; logic sm; int w, lat, bad_lat;
        bad_lat = 0;
        for (int n = 0; n < 1000; n++) begin
            w = n[0] ? 5 : 8;
            a = 16'($urandom & ((1 << w) - 1));
            b = 16'($urandom & ((1 << w) - 1));
            sm = 1'($urandom);
            do_op(w, a, b, sm, r, lat);
            if (lat != w + 1) bad_lat++;
            check($sformatf("rnd%0d_w%0d_%h_%h_s%0d", n, w, a, b, sm), 32'(r), 32'(ref_mul(w, a, b, sm)));
        end
        check("rnd_latency", 32'(bad_lat), 0);
    endtask

    initial begin
        test_reset();
        test_width3();
        test_corners();
        test_latency();
        test_back_to_back();
        test_busy_ignore();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
